// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller, byte loads/stores, 4-byte lines.
// Ports: CLK/RESET; CPU side READ, WRITE, ADDRESS, WRITEDATA, READDATA, BUSYWAIT;
// memory side MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_READDATA,
// MEM_BUSYWAIT. Optional `DCACHE_STATS_EN adds HIT_COUNT / MISS_COUNT.
module dcache_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);
    localparam int TAG_W = 6 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FETCH
    } state_t;

    state_t r_state, w_next_state;

    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    logic             r_mem_read, r_mem_write;
    logic [5:0]       r_mem_addr;
    logic [31:0]      r_mem_wdata;

    logic             w_mem_read, w_mem_write;
    logic [5:0]       w_mem_addr;
    logic [31:0]      w_mem_wdata;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_idx;
    logic [1:0]            w_off;
    logic                  w_req, w_hit, w_idle;
    logic                  w_hit_accept, w_miss_start, w_fill_done;

    assign w_tag  = ADDRESS[7:2+INDEX_BITS];
    assign w_idx  = ADDRESS[1+INDEX_BITS:2];
    assign w_off  = ADDRESS[1:0];
    assign w_req  = READ | WRITE;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle = (r_state == S_IDLE);

    assign w_hit_accept = w_idle && w_req && w_hit;
    assign w_miss_start = w_idle && w_req && !w_hit;
    assign w_fill_done  = (r_state == S_FETCH) && !MEM_BUSYWAIT;

    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        unique case (r_state)
            S_IDLE: begin
                if (w_miss_start) begin
                    if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        w_next_state = S_WRITEBACK;
                        w_mem_write  = 1'b1;
                        w_mem_addr   = {r_tag[w_idx], w_idx};
                        w_mem_wdata  = r_data[w_idx];
                    end else begin
                        w_next_state = S_FETCH;
                        w_mem_read   = 1'b1;
                        w_mem_addr   = {w_tag, w_idx};
                    end
                end
            end
            S_WRITEBACK: begin
                if (!MEM_BUSYWAIT) begin
                    w_next_state = S_FETCH;
                    w_mem_read   = 1'b1;
                    w_mem_addr   = {w_tag, w_idx};
                end else begin
                    w_mem_write  = 1'b1;
                end
            end
            S_FETCH: begin
                if (!MEM_BUSYWAIT) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_mem_read   = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_next_state;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            if (w_fill_done) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_hit_accept && WRITE) begin
                r_dirty[w_idx] <= 1'b1;
            end
        end
    end

    // Tag and data carry no reset; RESET only blocks updates so an
    // abandoned refill leaves the line untouched.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (w_fill_done) begin
                r_data[w_idx] <= MEM_READDATA;
                r_tag[w_idx]  <= w_tag;
            end else if (w_hit_accept && WRITE) begin
                r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
            end
        end
    end

    assign BUSYWAIT = !RESET && (!w_idle || w_miss_start);
    // WRITE wins when both requests are raised, so no load data then.
    assign READDATA = (!RESET && w_hit_accept && !WRITE)
                    ? r_data[w_idx][{w_off, 3'b000} +: 8] : 8'h00;

    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_addr;
    assign MEM_WRITEDATA = r_mem_wdata;

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_accept && (r_hit_cnt != 16'hFFFF))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss_start && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign HIT_COUNT  = r_hit_cnt;
    assign MISS_COUNT = r_miss_cnt;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table plus
// hand-written reset-mid-fetch sequence against a small memory model.
module tb_dcache_ctrl;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ, MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

    dcache_ctrl #(.INDEX_BITS(3)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: 3 busy cycles per transfer, then one ready cycle.
    localparam int LAT = 3;
    int          cnt = 0;
    int          n_fetch = 0;
    int          n_wb = 0;
    logic [5:0]  last_faddr = '0;
    logic [5:0]  last_wbaddr = '0;
    logic [31:0] last_wbdata = '0;
    logic        overlap = 1'b0;
    logic        w_mreq;

    function automatic logic [31:0] mem_val(input logic [5:0] a);
        case (a)
            6'h05:   mem_val = 32'hDDCCBBAA;
            6'h0D:   mem_val = 32'h44332211;
            6'h15:   mem_val = 32'h87654321;
            6'h02:   mem_val = 32'hA5A55A5A;
            6'h0A:   mem_val = 32'h0F0E0D0C;
            6'h10:   mem_val = 32'h13579BDF;
            default: mem_val = 32'h00000000;
        endcase
    endfunction

    assign w_mreq       = MEM_READ | MEM_WRITE;
    assign MEM_BUSYWAIT = !(w_mreq && cnt == LAT);
    assign MEM_READDATA = mem_val(MEM_ADDRESS);

    always @(posedge CLK) begin
        if (w_mreq) begin
            if (cnt == LAT) begin
                cnt <= 0;
                if (MEM_READ) begin
                    n_fetch    <= n_fetch + 1;
                    last_faddr <= MEM_ADDRESS;
                end
                if (MEM_WRITE) begin
                    n_wb        <= n_wb + 1;
                    last_wbaddr <= MEM_ADDRESS;
                    last_wbdata <= MEM_WRITEDATA;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
        if (MEM_READ && MEM_WRITE) overlap <= 1'b1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns after the accepting edge.
    task automatic access(input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] wd,
                          output logic [7:0] rdata, output int stalls);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        stalls = 0;
        @(negedge CLK);
        while (BUSYWAIT && stalls < 100) begin
            stalls++;
            @(negedge CLK);
        end
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        int          stalls;
        int          nf;
        int          nw;
        logic [5:0]  faddr;
        logic [5:0]  wbaddr;
        logic [31:0] wbdata;
    } vec_t;

    vec_t        vecs[13];
    logic [7:0]  rdata;
    int          stalls;
    int          f0, w0;

    initial begin
        vecs[0]  = '{1, 0, 8'h14, 8'h00, 8'hAA, 5, 1, 0, 6'h05, 6'h00, 32'h0};
        vecs[1]  = '{1, 0, 8'h17, 8'h00, 8'hDD, 0, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[2]  = '{0, 1, 8'h15, 8'h55, 8'h00, 0, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[3]  = '{1, 0, 8'h15, 8'h00, 8'h55, 0, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[4]  = '{1, 0, 8'h34, 8'h00, 8'h11, 9, 1, 1, 6'h0D, 6'h05, 32'hDDCC55AA};
        vecs[5]  = '{1, 0, 8'h37, 8'h00, 8'h44, 0, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[6]  = '{1, 0, 8'h54, 8'h00, 8'h21, 5, 1, 0, 6'h15, 6'h00, 32'h0};
        vecs[7]  = '{1, 0, 8'h08, 8'h00, 8'h5A, 5, 1, 0, 6'h02, 6'h00, 32'h0};
        vecs[8]  = '{1, 1, 8'h0A, 8'h3C, 8'h00, 0, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[9]  = '{1, 0, 8'h0A, 8'h00, 8'h3C, 0, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[10] = '{0, 1, 8'h28, 8'h77, 8'h00, 9, 1, 1, 6'h0A, 6'h02, 32'hA53C5A5A};
        vecs[11] = '{1, 0, 8'h28, 8'h00, 8'h77, 0, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[12] = '{1, 0, 8'h2B, 8'h00, 8'h0F, 0, 0, 0, 6'h00, 6'h00, 32'h0};

        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        READ = 1'b1; ADDRESS = 8'h14;
        @(negedge CLK);
        chk("rst_busywait", {31'b0, BUSYWAIT}, 32'd0);
        chk("rst_readdata", {24'b0, READDATA}, 32'd0);
        chk("rst_mem_read", {31'b0, MEM_READ}, 32'd0);
        chk("rst_mem_write", {31'b0, MEM_WRITE}, 32'd0);
        chk("rst_mem_addr", {26'b0, MEM_ADDRESS}, 32'd0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        READ = 1'b0; RESET = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 13; i++) begin
            f0 = n_fetch; w0 = n_wb;
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                   rdata, stalls);
            chk($sformatf("v%0d_readdata", i), {24'b0, rdata},
                {24'b0, vecs[i].exp_rd});
            chk($sformatf("v%0d_stalls", i), stalls, vecs[i].stalls);
            chk($sformatf("v%0d_fetches", i), n_fetch - f0, vecs[i].nf);
            chk($sformatf("v%0d_writebacks", i), n_wb - w0, vecs[i].nw);
            if (vecs[i].nf > 0)
                chk($sformatf("v%0d_fetch_addr", i), {26'b0, last_faddr},
                    {26'b0, vecs[i].faddr});
            if (vecs[i].nw > 0) begin
                chk($sformatf("v%0d_wb_addr", i), {26'b0, last_wbaddr},
                    {26'b0, vecs[i].wbaddr});
                chk($sformatf("v%0d_wb_data", i), last_wbdata,
                    vecs[i].wbdata);
            end
        end

        // Reset while a refill is in flight.
        READ = 1'b1; ADDRESS = 8'h40;
        @(negedge CLK);
        chk("midf_busy_idle", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK);
        chk("midf_mem_read", {31'b0, MEM_READ}, 32'd1);
        chk("midf_mem_addr", {26'b0, MEM_ADDRESS}, 32'h10);
        f0 = n_fetch;
        RESET = 1'b1;
        @(negedge CLK);
        chk("midf_rst_mem_read", {31'b0, MEM_READ}, 32'd0);
        chk("midf_rst_mem_addr", {26'b0, MEM_ADDRESS}, 32'd0);
        chk("midf_rst_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("midf_rst_readdata", {24'b0, READDATA}, 32'd0);
        RESET = 1'b0; READ = 1'b0;
        @(negedge CLK);
        chk("midf_idle_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("midf_idle_mem_read", {31'b0, MEM_READ}, 32'd0);
        chk("midf_no_fetch", n_fetch - f0, 32'd0);
        @(posedge CLK);
        #1;
        access(1'b1, 1'b0, 8'h40, 8'h00, rdata, stalls);
        chk("rr40_readdata", {24'b0, rdata}, 32'hDF);
        chk("rr40_stalls", stalls, 32'd5);
        chk("rr40_fetches", n_fetch - f0, 32'd1);
        access(1'b1, 1'b0, 8'h14, 8'h00, rdata, stalls);
        chk("rr14_readdata", {24'b0, rdata}, 32'hAA);
        chk("rr14_stalls", stalls, 32'd5);
        chk("rr14_fetches", n_fetch - f0, 32'd2);
        chk("no_overlap", {31'b0, overlap}, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("hit_count", {16'b0, HIT_COUNT}, 32'd2);
        chk("miss_count", {16'b0, MISS_COUNT}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
